// File: rtl/sfp_link_ctrl.sv
// SFP link bring-up and recovery controller: sequences laser enable and PMA reset
// against module status and PCS block lock, with automatic recovery and fault back-off.
module sfp_link_ctrl #(
    parameter int unsigned TX_INIT_CYCLES      = 100000,
    parameter int unsigned RESET_CYCLES        = 1000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned FAULT_HOLD_CYCLES   = 10000000,
    parameter int unsigned DEBOUNCE_CYCLES     = 1000
) (
    input  logic       clk100,
    input  logic       cold_reset_n,
    input  logic       enable,
    input  logic       sfp_tx_fault,
    input  logic       sfp_rx_los,
    input  logic       pcs_block_lock,
    output logic       sfp_tx_disable,
    output logic       pma_reset,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_count
);

    localparam int unsigned TIMER_W = 32;
    localparam int unsigned RETRY_W = 8;
    localparam int unsigned SYNC_W  = 3;

    localparam logic [TIMER_W-1:0] TX_INIT_LOAD = TIMER_W'(TX_INIT_CYCLES - 32'd1);
    localparam logic [TIMER_W-1:0] RESET_LOAD   = TIMER_W'(RESET_CYCLES - 32'd1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD    = TIMER_W'(LOCK_TIMEOUT_CYCLES - 32'd1);
    localparam logic [TIMER_W-1:0] FAULT_LOAD   = TIMER_W'(FAULT_HOLD_CYCLES - 32'd1);
    localparam logic [TIMER_W-1:0] DEBOUNCE_MAX = TIMER_W'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_TX_WAIT   = 3'd1,
        S_SIG_WAIT  = 3'd2,
        S_PMA_RST   = 3'd3,
        S_LOCK_WAIT = 3'd4,
        S_UP        = 3'd5,
        S_FAULT     = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TIMER_W-1:0]   deb_q, deb_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 tx_disable_q, tx_disable_d;
    logic                 pma_reset_q, pma_reset_d;
    logic                 link_up_q, link_up_d;

    logic [SYNC_W-1:0]    sync_meta_q, sync_q;
    logic                 fault_s, los_s, lock_s;

    // Two-flop synchronizers for the asynchronous status pins
    always_ff @(posedge clk100 or negedge cold_reset_n) begin
        if (!cold_reset_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= {sfp_tx_fault, sfp_rx_los, pcs_block_lock};
            sync_q      <= sync_meta_q;
        end
    end

    assign fault_s = sync_q[2];
    assign los_s   = sync_q[1];
    assign lock_s  = sync_q[0];

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
    endfunction

    // State, timers and registered outputs
    always_ff @(posedge clk100 or negedge cold_reset_n) begin
        if (!cold_reset_n) begin
            state_q      <= S_OFF;
            timer_q      <= '0;
            deb_q        <= '0;
            retry_q      <= '0;
            tx_disable_q <= 1'b1;
            pma_reset_q  <= 1'b1;
            link_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            deb_q        <= deb_d;
            retry_q      <= retry_d;
            tx_disable_q <= tx_disable_d;
            pma_reset_q  <= pma_reset_d;
            link_up_q    <= link_up_d;
        end
    end

    // Next-state logic: enable, then module fault, then per-state transitions
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
        deb_d   = deb_q;
        retry_d = retry_q;

        if (!enable) begin
            state_d = S_OFF;
        end else if (fault_s && (state_q inside {S_TX_WAIT, S_SIG_WAIT, S_PMA_RST,
                                                   S_LOCK_WAIT, S_UP})) begin
            state_d = S_FAULT;
            retry_d = sat_inc(retry_q);
            timer_d = FAULT_LOAD;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (!fault_s) begin
                        state_d = S_TX_WAIT;
                        timer_d = TX_INIT_LOAD;
                    end
                end
                S_TX_WAIT: begin
                    if (timer_q == '0) state_d = S_SIG_WAIT;
                end
                S_SIG_WAIT: begin
                    if (!los_s) begin
                        state_d = S_PMA_RST;
                        timer_d = RESET_LOAD;
                    end
                end
                S_PMA_RST: begin
                    if (timer_q == '0) begin
                        state_d = S_LOCK_WAIT;
                        timer_d = LOCK_LOAD;
                    end
                end
                S_LOCK_WAIT: begin
                    if (los_s) begin
                        state_d = S_SIG_WAIT;
                    end else if (lock_s) begin
                        state_d = S_UP;
                        deb_d   = '0;
                    end else if (timer_q == '0) begin
                        state_d = S_FAULT;
                        retry_d = sat_inc(retry_q);
                        timer_d = FAULT_LOAD;
                    end
                end
                S_UP: begin
                    if (los_s) begin
                        state_d = S_SIG_WAIT;
                    end else if (!lock_s) begin
                        deb_d = deb_q + TIMER_W'(1);
                        if (deb_d == DEBOUNCE_MAX) begin
                            state_d = S_PMA_RST;
                            retry_d = sat_inc(retry_q);
                            timer_d = RESET_LOAD;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
                S_FAULT: begin
                    if (timer_q == '0) state_d = S_OFF;
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // Output decode from the next state so outputs move on the same edge as state
    always_comb begin
        tx_disable_d = 1'b1;
        pma_reset_d  = 1'b1;
        link_up_d    = 1'b0;
        case (state_d)
            S_TX_WAIT, S_SIG_WAIT, S_PMA_RST: begin
                tx_disable_d = 1'b0;
            end
            S_LOCK_WAIT: begin
                tx_disable_d = 1'b0;
                pma_reset_d  = 1'b0;
            end
            S_UP: begin
                tx_disable_d = 1'b0;
                pma_reset_d  = 1'b0;
                link_up_d    = 1'b1;
            end
            default: begin
                tx_disable_d = 1'b1;
                pma_reset_d  = 1'b1;
            end
        endcase
    end

    assign sfp_tx_disable = tx_disable_q;
    assign pma_reset      = pma_reset_q;
    assign link_up        = link_up_q;
    assign state          = state_q;
    assign retry_count    = retry_q;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Self-checking bench for sfp_link_ctrl: directed scenarios plus randomized pin
// activity, compared every cycle against a dwell-time based reference model.
module tb_sfp_link_ctrl;

    localparam int TX_INIT = 8;
    localparam int RST_CYC = 4;
    localparam int LOCK_TO = 16;
    localparam int F_HOLD  = 10;
    localparam int DEB     = 3;

    localparam int ST_OFF = 0, ST_TXW = 1, ST_SIG = 2, ST_PMA = 3;
    localparam int ST_LOCK = 4, ST_UP = 5, ST_FAULT = 6;

    logic       clk100 = 1'b0;
    logic       cold_reset_n = 1'b1;
    logic       enable = 1'b1;
    logic       sfp_tx_fault = 1'b0;
    logic       sfp_rx_los = 1'b0;
    logic       pcs_block_lock = 1'b1;
    logic       sfp_tx_disable;
    logic       pma_reset;
    logic       link_up;
    logic [2:0] state;
    logic [7:0] retry_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state name, cycles spent in it, lost-lock run, retry total
    int m_state, m_dwell, m_lost, m_retry;
    bit [1:0] h_fault, h_los, h_lock;

    sfp_link_ctrl #(
        .TX_INIT_CYCLES(TX_INIT), .RESET_CYCLES(RST_CYC), .LOCK_TIMEOUT_CYCLES(LOCK_TO),
        .FAULT_HOLD_CYCLES(F_HOLD), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk100(clk100), .cold_reset_n(cold_reset_n), .enable(enable),
        .sfp_tx_fault(sfp_tx_fault), .sfp_rx_los(sfp_rx_los),
        .pcs_block_lock(pcs_block_lock), .sfp_tx_disable(sfp_tx_disable),
        .pma_reset(pma_reset), .link_up(link_up), .state(state),
        .retry_count(retry_count)
    );

    always #5 clk100 = ~clk100;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ST_OFF;
        m_dwell = 1;
        m_lost  = 0;
        m_retry = 0;
        h_fault = '0;
        h_los   = '0;
        h_lock  = '0;
    endtask

    function automatic int bump(input int r);
        return (r >= 255) ? 255 : r + 1;
    endfunction

    // One clock edge of the model; pin values reach the decision two edges late
    task automatic model_update();
        bit fs, ls, ks;
        int nxt;
        fs  = h_fault[1];
        ls  = h_los[1];
        ks  = h_lock[1];
        nxt = m_state;
        if (!enable) begin
            nxt = ST_OFF;
        end else if (fs && m_state != ST_OFF && m_state != ST_FAULT) begin
            nxt = ST_FAULT;
            m_retry = bump(m_retry);
        end else begin
            case (m_state)
                ST_OFF:   if (!fs) nxt = ST_TXW;
                ST_TXW:   if (m_dwell == TX_INIT) nxt = ST_SIG;
                ST_SIG:   if (!ls) nxt = ST_PMA;
                ST_PMA:   if (m_dwell == RST_CYC) nxt = ST_LOCK;
                ST_LOCK: begin
                    if (ls) nxt = ST_SIG;
                    else if (ks) begin nxt = ST_UP; m_lost = 0; end
                    else if (m_dwell == LOCK_TO) begin nxt = ST_FAULT; m_retry = bump(m_retry); end
                end
                ST_UP: begin
                    if (ls) nxt = ST_SIG;
                    else if (!ks) begin
                        m_lost++;
                        if (m_lost == DEB) begin nxt = ST_PMA; m_retry = bump(m_retry); end
                    end else m_lost = 0;
                end
                ST_FAULT: if (m_dwell == F_HOLD) nxt = ST_OFF;
                default:  nxt = ST_OFF;
            endcase
        end
        m_dwell = (nxt != m_state) ? 1 : m_dwell + 1;
        m_state = nxt;
        h_fault = {h_fault[0], sfp_tx_fault};
        h_los   = {h_los[0], sfp_rx_los};
        h_lock  = {h_lock[0], pcs_block_lock};
    endtask

    task automatic check_outputs();
        check_eq("state", state, m_state);
        check_eq("link_up", link_up, (m_state == ST_UP));
        check_eq("tx_disable", sfp_tx_disable, (m_state == ST_OFF || m_state == ST_FAULT));
        check_eq("pma_reset", pma_reset, !(m_state == ST_LOCK || m_state == ST_UP));
        check_eq("retry_count", retry_count, m_retry);
    endtask

    // Advance one edge, check everything, return at the falling edge for new stimulus
    task automatic tick();
        @(posedge clk100);
        model_update();
        #1;
        check_outputs();
        @(negedge clk100);
    endtask

    task automatic run_until(input int target, input int max_ticks, input string tag);
        int n = 0;
        while (int'(state) != target && n < max_ticks) begin
            tick();
            n++;
        end
        check_eq(tag, state, target);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, state, ST_OFF);
        check_eq({tag, "_txdis"}, sfp_tx_disable, 1);
        check_eq({tag, "_pma"}, pma_reset, 1);
        check_eq({tag, "_link"}, link_up, 0);
    endtask

    task automatic bringup_edges(input string tag);
        int edges[5] = '{1, 9, 10, 14, 15};
        int k = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e == edges[k]) begin
                check_eq(tag, state, k + 1);
                k++;
            end
        end
        check_eq({tag, "_link"}, link_up, 1);
    endtask

    initial begin
        int saved, n;
        model_reset();
        #1 cold_reset_n = 1'b0;
        #2;
        check_reset_values("rst");
        check_eq("rst_retry", retry_count, 0);
        @(negedge clk100);
        @(negedge clk100);
        cold_reset_n = 1'b1;

        bringup_edges("bringup");
        repeat (3) tick();

        // Short lock drop is absorbed, longer one forces a PMA reset
        saved = m_retry;
        pcs_block_lock = 1'b0;
        repeat (2) tick();
        pcs_block_lock = 1'b1;
        repeat (4) tick();
        check_eq("glitch_hold", state, ST_UP);
        check_eq("glitch_retry", retry_count, saved);
        pcs_block_lock = 1'b0;
        repeat (5) tick();
        check_eq("drop_state", state, ST_PMA);
        check_eq("drop_pma", pma_reset, 1);
        check_eq("drop_retry", retry_count, saved + 1);
        pcs_block_lock = 1'b1;
        run_until(ST_UP, 50, "relock_up");

        // One-cycle TX fault pulse in UP
        saved = m_retry;
        sfp_tx_fault = 1'b1;
        tick();
        sfp_tx_fault = 1'b0;
        repeat (2) tick();
        check_eq("fault_state", state, ST_FAULT);
        check_eq("fault_link", link_up, 0);
        check_eq("fault_txdis", sfp_tx_disable, 1);
        check_eq("fault_retry", retry_count, saved + 1);
        run_until(ST_UP, 100, "fault_recover");

        // Lock timeout: dwell lengths of LOCK_WAIT and FAULT
        pcs_block_lock = 1'b0;
        run_until(ST_LOCK, 100, "reach_lock");
        saved = m_retry;
        n = 0;
        while (int'(state) == ST_LOCK && n < 100) begin tick(); n++; end
        check_eq("lock_dwell", n, LOCK_TO);
        check_eq("timeout_retry", retry_count, saved + 1);
        n = 0;
        while (int'(state) == ST_FAULT && n < 100) begin tick(); n++; end
        check_eq("fault_dwell", n, F_HOLD);
        run_until(ST_LOCK, 100, "retry_lock");

        // enable=0 on the same edge the synchronized fault arrives
        saved = m_retry;
        sfp_tx_fault = 1'b1;
        repeat (2) tick();
        enable = 1'b0;
        tick();
        check_eq("prio_state", state, ST_OFF);
        check_eq("prio_retry", retry_count, saved);
        sfp_tx_fault = 1'b0;
        enable = 1'b1;
        pcs_block_lock = 1'b1;

        // Randomized pin activity
        for (int i = 0; i < 3000; i++) begin
            enable       = ($urandom_range(0, 99) != 0);
            sfp_tx_fault = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) sfp_rx_los = ~sfp_rx_los;
            if ($urandom_range(0, 5) == 0) pcs_block_lock = ~pcs_block_lock;
            tick();
        end
        enable = 1'b1;
        sfp_tx_fault = 1'b0;
        sfp_rx_los = 1'b0;

        // Repeated lock timeouts saturate the retry counter
        pcs_block_lock = 1'b0;
        n = 0;
        while (retry_count != 8'd255 && n < 20000) begin tick(); n++; end
        check_eq("sat_reach", retry_count, 255);
        repeat (400) tick();
        check_eq("sat_hold", retry_count, 255);

        // Asynchronous reset between edges while UP
        pcs_block_lock = 1'b1;
        run_until(ST_UP, 200, "pre_reset_up");
        #2 cold_reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        check_eq("midrst_retry", retry_count, 0);
        model_reset();
        @(negedge clk100);
        cold_reset_n = 1'b1;
        bringup_edges("rebringup");
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
